sha256_round_core: RTL and testbench

Compression-side SHA-256 engine that drives the `ME` message-expansion block and consumes its schedule words. It accepts one 512-bit block as sixteen 32-bit words over a valid/ready stream and loads them into `ME`. It then runs 64 compression rounds on `W[t]` returned by `ME`, with the K constants held in an internal ROM. It accumulates the chaining value and presents a 256-bit digest.

---
 rtl/sha256_round_core.sv | 102 ++++++++++
 tb/tb_sha256_round_core.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sha256_round_core.sv
// sha256_round_core: SHA-256 compression engine that feeds an external message-expansion block and accumulates the digest
module sha256_round_core #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_in,
    input  logic                      first_block_in,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic                      data_valid_in,
    output logic                      data_ready_out,
    output logic [2:0]                me_fsm_out,
    output logic [6:0]                me_count_out,
    output logic [DATA_WIDTH-1:0]     me_data_out,
    input  logic [DATA_WIDTH-1:0]     me_w_in,
    output logic [8*DATA_WIDTH-1:0]   digest_out,
    output logic                      digest_valid_out,
    output logic                      busy_out
);
    localparam logic [2:0] IDLE   = 3'b000;
    localparam logic [2:0] LOAD   = 3'b010;
    localparam logic [2:0] ROUND  = 3'b011;
    localparam logic [2:0] UPDATE = 3'b100;
    localparam logic [2:0] DONE   = 3'b101;
    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic [2:0]   state;
    logic [6:0]   count;
    logic         first_q;
    logic [31:0]  a, b, c, d, e, f, g, h;
    logic [31:0]  t1, t2;
    logic [255:0] base, work, sum;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // The chaining value is digest_out itself; a first block substitutes the IV instead of copying it in
    assign base = first_q ? IV : digest_out;
    assign work = {a, b, c, d, e, f, g, h};
    assign t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[count[5:0]] + me_w_in;
    assign t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    assign data_ready_out   = (state == LOAD) && (count < 7'd16);
    assign me_fsm_out       = state;
    assign me_count_out     = count;
    assign digest_valid_out = (state == DONE);
    assign busy_out         = (state != IDLE);

    // Word-wise modulo-2^32 addition of the working registers onto the chaining value
    always_comb begin
        sum = '0;
        for (int i = 0; i < 8; i++) sum[32*i +: 32] = base[32*i +: 32] + work[32*i +: 32];
    end

    // Block sequencer: load sixteen words, run 64 rounds, fold into the digest
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            first_q     <= 1'b0;
            me_data_out <= '0;
            digest_out  <= '0;
            {a, b, c, d, e, f, g, h} <= '0;
        end else begin
            case (state)
                IDLE: if (start_in) begin
                    first_q <= first_block_in;
                    count   <= '0;
                    state   <= LOAD;
                end
                LOAD: if (count == 7'd16) begin
                    {a, b, c, d, e, f, g, h} <= base;
                    count <= '0;
                    state <= ROUND;
                end else if (data_valid_in) begin
                    me_data_out <= data_in;
                    count       <= count + 7'd1;
                end
                ROUND: begin
                    {a, b, c, d, e, f, g, h} <= {t1 + t2, a, b, c, d + t1, e, f, g};
                    count <= (count == 7'd63) ? 7'd0 : count + 7'd1;
                    state <= (count == 7'd63) ? UPDATE : ROUND;
                end
                UPDATE: begin
                    digest_out <= sum;
                    state      <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_round_core.sv
// tb_sha256_round_core: randomized self-checking bench with an ME model and a reference SHA-256 compression
module tb_sha256_round_core;
    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [511:0] ABC  = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [255:0] ABC_D = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [511:0] TWO1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
                                     32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO2 = {480'h0, 32'h000001c0};
    localparam logic [255:0] TWO_D = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_in = 1'b0;
    logic         first_block_in = 1'b0;
    logic [31:0]  data_in = '0;
    logic         data_valid_in = 1'b0;
    logic         data_ready_out;
    logic [2:0]   me_fsm_out;
    logic [6:0]   me_count_out;
    logic [31:0]  me_data_out;
    logic [31:0]  me_w_in;
    logic [255:0] digest_out;
    logic         digest_valid_out;
    logic         busy_out;
    logic [511:0] me_mem = '0;
    logic [255:0] href = '0;
    int           errors = 0;
    int           checks = 0;

    sha256_round_core #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start_in(start_in), .first_block_in(first_block_in),
        .data_in(data_in), .data_valid_in(data_valid_in), .data_ready_out(data_ready_out),
        .me_fsm_out(me_fsm_out), .me_count_out(me_count_out), .me_data_out(me_data_out),
        .me_w_in(me_w_in), .digest_out(digest_out), .digest_valid_out(digest_valid_out), .busy_out(busy_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] w_of(input logic [511:0] blk, input int t);
        logic [31:0] w [64];
        for (int i = 0; i < 64; i++) begin
            if (i < 16) w[i] = blk[511 - 32*i -: 32];
            else w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                      + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        end
        return w[t & 63];
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] v [8];
        logic [31:0] x1, x2;
        logic [255:0] r;
        for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            x1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w_of(blk, t);
            x2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + x1;
            v[0] = x1 + x2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
        return r;
    endfunction

    // ME model: stores word[count-1] the edge after each accept and serves W[t] combinationally
    always @(posedge clk)
        if (me_fsm_out == 3'b010 && me_count_out != 7'd0 && me_count_out <= 7'd16)
            me_mem[511 - 32*(int'(me_count_out) - 1) -: 32] <= me_data_out;
    assign me_w_in = (me_fsm_out == 3'b011) ? w_of(me_mem, int'(me_count_out)) : 32'h0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // mode 0: valid always high, 1: valid every other cycle, 2: random valid; poke_t: round index at which start_in is pulsed
    task automatic run_block(input logic [511:0] blk, input logic first, input int mode, input int poke_t,
                             output logic [255:0] dig, output int lat, output int stalls);
        int idx = 0, rexp = 0, gaps = 0, early = 0;
        bit done = 0;
        bit acc;
        logic [255:0] d0 = digest_out;
        lat = 0;
        stalls = 0;
        start_in = 1'b1;
        first_block_in = first;
        @(posedge clk); #1;
        start_in = 1'b0;
        check("load_fsm", me_fsm_out, 3'b010);
        while (!done && lat < 400) begin
            data_valid_in = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(lat % 2) : 1'($urandom_range(0, 1));
            data_in = (idx < 16) ? blk[511 - 32*idx -: 32] : $urandom;
            first_block_in = 1'($urandom_range(0, 1));
            start_in = (me_fsm_out == 3'b011 && me_count_out == 7'(poke_t));
            acc = data_valid_in && data_ready_out;
            if (me_fsm_out == 3'b010 && data_ready_out && !data_valid_in) stalls++;
            @(posedge clk); #1;
            lat++;
            if (acc) idx++;
            if (me_fsm_out == 3'b010 && me_count_out != 7'(idx)) gaps++;
            if (me_fsm_out == 3'b011) begin
                if (me_count_out != 7'(rexp)) gaps++;
                rexp++;
            end
            if (digest_valid_out) done = 1;
            else if (digest_out !== d0) early++;
        end
        start_in = 1'b0;
        data_valid_in = 1'b0;
        check("done_seen", 256'(done), 1);
        check("done_fsm", me_fsm_out, 3'b101);
        check("busy_done", busy_out, 1);
        check("rounds", rexp, 64);
        check("me_count_seq", gaps, 0);
        check("digest_early", early, 0);
        dig = digest_out;
        @(posedge clk); #1;
        check("idle_fsm", me_fsm_out, 3'b000);
        check("valid_pulse", digest_valid_out, 0);
        check("busy_idle", busy_out, 0);
        check("digest_hold", digest_out, dig);
    endtask

    task automatic do_block(input string tag, input logic [511:0] blk, input logic first, input int mode,
                            input int poke_t, output logic [255:0] dig, output int lat, output int stalls);
        logic [255:0] exp;
        run_block(blk, first, mode, poke_t, dig, lat, stalls);
        exp = compress(first ? IV : href, blk);
        href = exp;
        check(tag, dig, exp);
        check({tag, "_latency"}, lat, 82 + stalls);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_fsm"}, me_fsm_out, 0);
        check({tag, "_count"}, me_count_out, 0);
        check({tag, "_data"}, me_data_out, 0);
        check({tag, "_digest"}, digest_out, 0);
        check({tag, "_flags"}, {data_ready_out, digest_valid_out, busy_out}, 0);
    endtask

    initial begin
        logic [255:0] dig;
        logic [511:0] blk;
        int lat, stalls, idx;
        bit reached;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 16; k++) blk[511 - 32*k -: 32] = $urandom;
        do_block("chain_from_zero", blk, 1'b0, 0, -1, dig, lat, stalls);
        do_block("abc", ABC, 1'b1, 0, -1, dig, lat, stalls);
        check("abc_known", dig, ABC_D);
        check("abc_latency82", lat, 82);
        do_block("two_blk1", TWO1, 1'b1, 0, -1, dig, lat, stalls);
        do_block("two_blk2", TWO2, 1'b0, 0, -1, dig, lat, stalls);
        check("two_known", dig, TWO_D);
        do_block("abc_stall", ABC, 1'b1, 1, -1, dig, lat, stalls);
        check("abc_stall_known", dig, ABC_D);
        check("abc_stall_count", stalls, 16);
        do_block("abc_poke", ABC, 1'b1, 0, 20, dig, lat, stalls);
        check("abc_poke_known", dig, ABC_D);
        check("abc_poke_latency", lat, 82);
        for (int n = 0; n < 6; n++) begin
            for (int k = 0; k < 16; k++) blk[511 - 32*k -: 32] = $urandom;
            do_block("random", blk, (n == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 2, $urandom_range(0, 63), dig, lat, stalls);
        end
        start_in = 1'b1;
        first_block_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        idx = 0;
        reached = 0;
        for (int cyc = 0; cyc < 200 && !reached; cyc++) begin
            data_valid_in = 1'b1;
            data_in = (idx < 16) ? ABC[511 - 32*idx -: 32] : 32'h0;
            if (data_ready_out) idx++;
            @(posedge clk); #1;
            reached = (me_fsm_out == 3'b011 && me_count_out == 7'd30);
        end
        data_valid_in = 1'b0;
        check("reach_t30", 256'(reached), 1);
        rst_n = 1'b0;
        #2;
        check_reset_state("mid_reset");
        @(posedge clk); #1;
        check_reset_state("mid_reset_held");
        rst_n = 1'b1;
        href = '0;
        @(posedge clk); #1;
        do_block("abc_after_reset", ABC, 1'b1, 0, -1, dig, lat, stalls);
        check("abc_after_reset_known", dig, ABC_D);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
